// File: rtl/health_bar_if.sv
// Signal bundle between the HUD scan logic and the animated health bar.
// frame_clk is a level; its rising edge marks a new frame, and there is no valid/ready handshake anywhere on this bus.
interface health_bar_if #(
    parameter int VAL_W = 10,
    parameter int PIX_W = 9
);
    logic             frame_clk;
    logic [VAL_W-1:0] Player_Blood;
    logic [PIX_W-1:0] PixelX;
    logic [PIX_W-1:0] PixelY;
    logic             is_obj;
    logic [4:0]       Obj_Index;
    logic [VAL_W-1:0] dbg_shown;
    logic [VAL_W-1:0] dbg_trail;

    modport master (
        output frame_clk, Player_Blood, PixelX, PixelY,
        input  is_obj, Obj_Index, dbg_shown, dbg_trail
    );

    modport slave (
        input  frame_clk, Player_Blood, PixelX, PixelY,
        output is_obj, Obj_Index, dbg_shown, dbg_trail
    );
endinterface

// File: rtl/health_bar_anim.sv
// Animated HUD health bar: current fill, delayed damage trail, and empty remainder inside a border.
// Health is latched once per frame; pixel output is registered with one clock of latency.
module health_bar_anim #(
    parameter int VAL_W        = 10,
    parameter int PIX_W        = 9,
    parameter int X_POS        = 80,
    parameter int Y_POS        = 5,
    parameter int BAR_HEIGHT   = 20,
    parameter int BORDER       = 1,
    parameter int MAX_VAL      = 400,
    parameter int SHIFT        = 1,
    parameter int DRAIN_RATE   = 2,
    parameter int HOLD_FRAMES  = 8,
    parameter int LOW_THRESH   = 80,
    parameter int FLASH_PERIOD = 16,
    parameter int COLOR_FULL   = 16,
    parameter int COLOR_LOW    = 17,
    parameter int COLOR_TRAIL  = 15,
    parameter int COLOR_EMPTY  = 2,
    parameter int COLOR_BORDER = 1
) (
    input logic        Clk,
    input logic        Reset,
    health_bar_if.slave bus
);
    localparam int IW = MAX_VAL >> SHIFT;
    localparam int CW = (PIX_W + 1 > VAL_W + 1) ? PIX_W + 1 : VAL_W + 1;
    localparam int HW = $clog2(HOLD_FRAMES + 2);
    localparam int FW = $clog2(FLASH_PERIOD + 1);

    localparam logic [CW-1:0] X_LO  = CW'(X_POS);
    localparam logic [CW-1:0] X_HI  = CW'(X_POS + IW + 2 * BORDER);
    localparam logic [CW-1:0] Y_LO  = CW'(Y_POS);
    localparam logic [CW-1:0] Y_HI  = CW'(Y_POS + BAR_HEIGHT + 2 * BORDER);
    localparam logic [CW-1:0] XI_LO = CW'(X_POS + BORDER);
    localparam logic [CW-1:0] XI_HI = CW'(X_POS + BORDER + IW);
    localparam logic [CW-1:0] YI_LO = CW'(Y_POS + BORDER);
    localparam logic [CW-1:0] YI_HI = CW'(Y_POS + BORDER + BAR_HEIGHT);

    localparam logic [VAL_W-1:0] MAX_V      = VAL_W'(MAX_VAL);
    localparam logic [VAL_W-1:0] LOW_V      = VAL_W'(LOW_THRESH);
    localparam logic [VAL_W:0]   DRAIN_V    = (VAL_W + 1)'(DRAIN_RATE);
    localparam logic [HW-1:0]    HOLD_V     = HW'(HOLD_FRAMES);
    localparam logic [FW-1:0]    FLASH_LAST = FW'(FLASH_PERIOD - 1);
    localparam logic [FW-1:0]    FLASH_HALF = FW'(FLASH_PERIOD / 2);

    logic             frame_prev_q;
    logic [VAL_W-1:0] shown_q, shown_d;
    logic [VAL_W-1:0] trail_q, trail_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [FW-1:0]    flash_q, flash_d;
    logic             is_obj_q, is_obj_d;
    logic [4:0]       idx_q, idx_d;

    logic             tick;
    logic [VAL_W-1:0] new_val;
    logic [VAL_W:0]   drain_floor;

    assign tick        = bus.frame_clk & ~frame_prev_q;
    assign new_val     = (bus.Player_Blood > MAX_V) ? MAX_V : bus.Player_Blood;
    // Draining below new+rate would overshoot, so it snaps to new instead.
    assign drain_floor = {1'b0, new_val} + DRAIN_V;

    always_comb begin
        shown_d = shown_q;
        trail_d = trail_q;
        hold_d  = hold_q;
        flash_d = flash_q;
        if (tick) begin
            if (new_val >= trail_q) begin
                trail_d = new_val;
                hold_d  = '0;
            end else if (new_val < shown_q) begin
                hold_d = HOLD_V;
            end else if (hold_q != '0) begin
                hold_d = hold_q - HW'(1);
            end else if ({1'b0, trail_q} < drain_floor) begin
                trail_d = new_val;
            end else begin
                trail_d = trail_q - DRAIN_V[VAL_W-1:0];
            end
            shown_d = new_val;
            flash_d = (flash_q == FLASH_LAST) ? '0 : flash_q + FW'(1);
        end
    end

    logic [CW-1:0] px, py, dx, shown_px, trail_px;
    logic          in_box, in_int, low, flash_on;
    logic [4:0]    fill_idx;

    assign px       = CW'(bus.PixelX);
    assign py       = CW'(bus.PixelY);
    assign dx       = px - XI_LO;
    assign shown_px = CW'(shown_q >> SHIFT);
    assign trail_px = CW'(trail_q >> SHIFT);
    assign in_box   = (px >= X_LO) && (px < X_HI) && (py >= Y_LO) && (py < Y_HI);
    assign in_int   = (px >= XI_LO) && (px < XI_HI) && (py >= YI_LO) && (py < YI_HI);
    assign low      = (shown_q <= LOW_V) && (shown_q != '0);
    assign flash_on = flash_q < FLASH_HALF;
    assign fill_idx = (low && flash_on) ? 5'(COLOR_LOW) : 5'(COLOR_FULL);

    always_comb begin
        is_obj_d = in_box;
        idx_d    = '0;
        if (in_box) begin
            if (!in_int)             idx_d = 5'(COLOR_BORDER);
            else if (dx < shown_px)  idx_d = fill_idx;
            else if (dx < trail_px)  idx_d = 5'(COLOR_TRAIL);
            else                     idx_d = 5'(COLOR_EMPTY);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_prev_q <= 1'b0;
            shown_q      <= MAX_V;
            trail_q      <= MAX_V;
            hold_q       <= '0;
            flash_q      <= '0;
            is_obj_q     <= 1'b0;
            idx_q        <= '0;
        end else begin
            frame_prev_q <= bus.frame_clk;
            shown_q      <= shown_d;
            trail_q      <= trail_d;
            hold_q       <= hold_d;
            flash_q      <= flash_d;
            is_obj_q     <= is_obj_d;
            idx_q        <= idx_d;
        end
    end

    assign bus.is_obj    = is_obj_q;
    assign bus.Obj_Index = idx_q;
    assign bus.dbg_shown = shown_q;
    assign bus.dbg_trail = trail_q;
endmodule

// File: doc/health_bar_anim.md
Name: health_bar_anim

Overview:
Parametrised, animated successor to the static HUD health bar.
- Draws a bordered bar at a fixed screen position with three layers:
  - current health;
  - a delayed "damage trail" that holds, then drains toward current health;
  - empty remainder.
- Flashes the fill when health is low.
- Latches health once per frame so the bar never tears mid-scan.
- Feeds the palette mux alongside other HUD objects.

Parameters:
VAL_W, 10, width of health value
PIX_W, 9, width of PixelX/PixelY
X_POS, 80, left edge of outer box (incl. border)
Y_POS, 5, top edge of outer box
BAR_HEIGHT, 20, interior height in pixels
BORDER, 1, border thickness in pixels (0 = no border)
MAX_VAL, 400, full-health value; inputs above are clamped
SHIFT, 1, pixels per value = value >> SHIFT (interior width = MAX_VAL>>SHIFT)
DRAIN_RATE, 2, trail decrement per frame
HOLD_FRAMES, 8, frames trail holds after a damage event
LOW_THRESH, 80, low-health threshold (inclusive)
FLASH_PERIOD, 16, flash period in frames (even; on for first half)
COLOR_FULL, 16, palette index for fill
COLOR_LOW, 17, fill index during low-health flash-on
COLOR_TRAIL, 15, trail index
COLOR_EMPTY, 2, empty interior index
COLOR_BORDER, 1, border index

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
frame_clk  input  1  vsync-rate strobe; rising edge = new frame
Player_Blood  input  VAL_W  current player health
PixelX  input  PIX_W  scan X coordinate
PixelY  input  PIX_W  scan Y coordinate
is_obj  output  1  pixel belongs to the bar (registered)
Obj_Index  output  5  palette index (registered)

Behaviour:
- One clock, Clk. Reset is asynchronous and active-high.
- Reset values:
  - is_obj = 0, Obj_Index = 0
  - shown_val = MAX_VAL, trail_val = MAX_VAL
  - hold_cnt = 0, flash_cnt = 0, frame_prev = 0
- Frame tick: frame_prev <= frame_clk; tick = frame_clk & ~frame_prev. Tick is a one-Clk pulse.
- Clamp: new = min(Player_Blood, MAX_VAL). Player_Blood is sampled only on tick; changes between ticks are ignored.
- On each tick, evaluated in priority order with pre-tick register values:
  - new >= trail_val (heal or equal): trail_val <= new, hold_cnt <= 0.
  - else if new < shown_val (fresh damage): hold_cnt <= HOLD_FRAMES, trail_val unchanged.
  - else if hold_cnt != 0: hold_cnt <= hold_cnt - 1, trail unchanged.
  - else: trail_val <= max(trail_val - DRAIN_RATE, new). No underflow; compute at VAL_W+1 bits.
  - In all cases: shown_val <= new; flash_cnt <= (flash_cnt == FLASH_PERIOD-1) ? 0 : flash_cnt+1.
- Invariant: trail_val >= shown_val always.
- flash_on = flash_cnt < FLASH_PERIOD/2.
- low = (shown_val <= LOW_THRESH) && (shown_val != 0).
- Draw: registered, 1-Clk latency from PixelX/PixelY; uses register values as of the previous edge. A tick in the same cycle does not affect that pixel.
  - IW = MAX_VAL>>SHIFT; box x in [X_POS, X_POS+IW+2*BORDER), y in [Y_POS, Y_POS+BAR_HEIGHT+2*BORDER).
  - Outside box: is_obj=0, Obj_Index=0.
  - In box but within BORDER of any edge: COLOR_BORDER.
  - Interior, dx = PixelX - X_POS - BORDER:
    - dx < shown_val>>SHIFT: fill (COLOR_LOW if low && flash_on, else COLOR_FULL)
    - else if dx < trail_val>>SHIFT: COLOR_TRAIL
    - else: COLOR_EMPTY
  - is_obj=1 everywhere in box.
- Comparisons are unsigned at PIX_W+1 bits so X_POS+width never wraps.
- Reset mid-drain: all state returns to reset values immediately. The next pixel after release draws a full bar.

Test Plan:
- Reset, release, PixelX=100, PixelY=10 -> next cycle is_obj=1, Obj_Index=16. Pixel (80,5) -> 1. Pixel (79,5) -> is_obj=0, Obj_Index=0.
- Player_Blood 400->300, one tick -> shown=300, trail=400.
  - Pixel (241,10), dx=160 -> 15.
  - Trail stays 400 for 9 ticks, then drains 2/tick and reaches 300 on tick 59 (damage tick = 1). After that, pixel (241,10) -> 2.
- During drain (trail=350), Player_Blood=380, tick -> trail=380, shown=380, hold_cnt=0. Pixel (241,10) -> 16.
- Player_Blood=50 -> fill index toggles: 17 for 8 ticks, 16 for 8 ticks. Player_Blood=0 -> no flash; interior shows trail/empty only.
- Player_Blood=1023, tick -> shown=400 (clamp). Change Player_Blood between ticks -> bar unchanged until next frame_clk rising edge.
- Assert Reset at tick 20 of a drain -> outputs 0 during reset. After release: shown=trail=400, flash_cnt=0.
